seven_segment_scanner: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the board output port. A write strobe latches a packed hex value plus per-digit decimal points. The block then scans DIGITS common-anode/cathode digits round-robin from a single shared segment bus. It decodes each nibble to 0–F glyphs and inserts a one-cycle blanking gap between digits to suppress ghosting.

---
 rtl/seven_seg_pkg.sv | 16 +
 rtl/seven_seg_hex_decode.sv | 11 +
 rtl/seven_segment_scanner.sv | 98 +++++++++
 tb/tb_seven_segment_scanner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and hex-to-glyph helper for the seven-segment scanner.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Index n holds the gfedcba glyph for hex digit n (entry 0 is rightmost).
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble to 7-segment glyph (gfedcba, 1 = lit).
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed DIGITS-wide seven-segment driver with a blank cycle between digits.
// Optional LEADING_ZERO_BLANK_EN macro suppresses segments of leading zero digits.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS     = 2,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [DIGITS-1:0][3:0] data_q;
    logic [DIGITS-1:0]      dp_q;
    logic [CNT_W-1:0]       div_cnt;
    logic [IDX_W-1:0]       idx;
    logic                   tick;
    logic [3:0]             nib;
    logic [6:0]             glyph;
    logic [6:0]             seg_d;

    logic [6:0]             seg_q;
    logic                   dpo_q;
    logic [DIGITS-1:0]      sel_q;

    assign tick = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign nib  = data_q[idx];

    seven_seg_hex_decode u_dec (
        .nibble (nib),
        .seg    (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // The mask is derived from data_q and folded into the output register,
    // so it lands in the same stage as seg_out and adds no write latency.
    logic [DIGITS-1:0] lz_mask;
    logic              hi_zero;

    always_comb begin
        lz_mask = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            hi_zero    = hi_zero & (data_q[i] == 4'h0);
            lz_mask[i] = hi_zero;
        end
    end

    assign seg_d = lz_mask[idx] ? SEG_OFF : glyph;
`else
    assign seg_d = glyph;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_q  <= '0;
            dp_q    <= '0;
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            if (wr_en) begin
                data_q <= wr_data;
                dp_q   <= wr_dp;
            end
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // The tick cycle is the blank gap that suppresses ghosting between digits.
    always_ff @(posedge clock) begin
        if (!reset_n || tick) begin
            sel_q <= '0;
            seg_q <= SEG_OFF;
            dpo_q <= 1'b0;
        end else begin
            sel_q <= DIGITS'(1) << idx;
            seg_q <= seg_d;
            dpo_q <= dp_q[idx];
        end
    end

    assign seg_out   = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp_out    = (ACTIVE_LOW != 0) ? ~dpo_q : dpo_q;
    assign digit_sel = (ACTIVE_LOW != 0) ? ~sel_q : sel_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (DIGITS=2, CLK_DIV=4), both polarities.
module tb_seven_segment_scanner;

    typedef struct packed {
        logic [1:0] sel;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] wr_dp = 2'b00;

    logic [6:0] seg_out, seg_out_al;
    logic       dp_out, dp_out_al;
    logic [1:0] digit_sel, digit_sel_al;

    int         checks = 0;
    int         errors = 0;
    int         ne = 0;
    logic [7:0] vis_d = 8'h00;
    logic [1:0] vis_dp = 2'b00;
    exp_t       sb[$];
    logic [6:0] glyph [16];

    always #5 clock = ~clock;

    seven_segment_scanner #(.DIGITS(2), .CLK_DIV(4), .ACTIVE_LOW(0)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_dp     (wr_dp),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .digit_sel (digit_sel)
    );

    seven_segment_scanner #(.DIGITS(2), .CLK_DIV(4), .ACTIVE_LOW(1)) dut_al (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_dp     (wr_dp),
        .seg_out   (seg_out_al),
        .dp_out    (dp_out_al),
        .digit_sel (digit_sel_al)
    );

    // Expected pin state at edge n (counted from reset release) from frame position.
    function automatic exp_t model(int n, logic [7:0] d, logic [1:0] p, logic rst);
        exp_t       e;
        int         pos;
        int         dig;
        logic [3:0] nb;
        e = '0;
        if (!rst) return e;
        pos = n % 8;
        dig = pos / 4;
        if (pos % 4 == 3) return e;
        nb = (dig == 1) ? d[7:4] : d[3:0];
        e.sel = (dig == 1) ? 2'b10 : 2'b01;
        e.seg = glyph[nb];
`ifdef LEADING_ZERO_BLANK_EN
        if (dig == 1 && d[7:4] == 4'h0) e.seg = 7'h00;
`endif
        e.dp = p[dig];
        return e;
    endfunction

    // Push the expectation for the coming edge, clock it, pop it back with the DUT sample.
    task automatic step(output exp_t ev, output logic [9:0] g, output logic [9:0] ga);
        sb.push_back(model(ne, vis_d, vis_dp, reset_n));
        @(posedge clock);
        if (!reset_n) begin
            vis_d = 8'h00; vis_dp = 2'b00; ne = 0;
        end else begin
            if (wr_en) begin vis_d = wr_data; vis_dp = wr_dp; end
            ne++;
        end
        #1;
        g  = {digit_sel, seg_out, dp_out};
        ga = {digit_sel_al, seg_out_al, dp_out_al};
        ev = sb.pop_front();
    endtask

    task automatic do_reset();
        exp_t e; logic [9:0] g, ga;
        reset_n = 1'b0; wr_en = 1'b0;
        step(e, g, ga);
        step(e, g, ga);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e; logic [9:0] g, ga;
        reset_n = 1'b0; wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(e, g, ga);
            checks++;
            if (g !== 10'h000) begin errors++; $display("FAIL reset_hold cyc %0d: got %h expected 000", k, g); end
            checks++;
            if (ga !== 10'h3FF) begin errors++; $display("FAIL reset_hold_al cyc %0d: got %h expected 3ff", k, ga); end
        end
        reset_n = 1'b1;
        step(e, g, ga);
        checks++;
        if (g !== {2'b01, 7'h3F, 1'b0}) begin errors++; $display("FAIL reset_edge0: got %h expected %h", g, {2'b01, 7'h3F, 1'b0}); end
    endtask

    task automatic test_scan();
        exp_t e; logic [9:0] g, ga;
        do_reset();
        wr_en = 1'b1; wr_data = 8'h3A; wr_dp = 2'b10;
        for (int k = 0; k < 16; k++) begin
            step(e, g, ga);
            wr_en = 1'b0;
            checks++;
            if (g !== e) begin errors++; $display("FAIL scan edge %0d: got %h expected %h", k, g, e); end
            checks++;
            if (ga !== ~e) begin errors++; $display("FAIL scan_al edge %0d: got %h expected %h", k, ga, ~e); end
            if (k == 2 || k == 8) begin
                checks++;
                if (g !== {2'b01, 7'h77, 1'b0}) begin errors++; $display("FAIL scan_dig0 edge %0d: got %h", k, g); end
            end
            if (k == 3 || k == 7) begin
                checks++;
                if (g[9:8] !== 2'b00) begin errors++; $display("FAIL scan_blank edge %0d: got sel %b expected 00", k, g[9:8]); end
            end
            if (k == 6) begin
                checks++;
                if (g !== {2'b10, 7'h4F, 1'b1}) begin errors++; $display("FAIL scan_dig1 edge %0d: got %h", k, g); end
            end
        end
    endtask

    task automatic test_write_on_tick();
        exp_t e; logic [9:0] g, ga;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k == 3) begin wr_en = 1'b1; wr_data = 8'h5C; wr_dp = 2'b00; end
            step(e, g, ga);
            wr_en = 1'b0;
            checks++;
            if (g !== e) begin errors++; $display("FAIL tick_write edge %0d: got %h expected %h", k, g, e); end
            if (k == 4) begin
                checks++;
                if (g !== {2'b10, 7'h6D, 1'b0}) begin errors++; $display("FAIL tick_write_first edge 4: got %h expected %h", g, {2'b10, 7'h6D, 1'b0}); end
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e; logic [9:0] g, ga;
        do_reset();
        wr_en = 1'b1; wr_data = 8'h3A; wr_dp = 2'b10;
        for (int k = 0; k < 6; k++) begin
            step(e, g, ga);
            wr_en = 1'b0;
            checks++;
            if (g !== e) begin errors++; $display("FAIL midrst_pre edge %0d: got %h expected %h", k, g, e); end
        end
        reset_n = 1'b0;
        step(e, g, ga);
        checks++;
        if (g !== 10'h000) begin errors++; $display("FAIL midrst_abort: got %h expected 000", g); end
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(e, g, ga);
            checks++;
            if (g !== e) begin errors++; $display("FAIL midrst_post edge %0d: got %h expected %h", k, g, e); end
            if (k == 0 && g !== {2'b01, 7'h3F, 1'b0}) begin errors++; $display("FAIL midrst_restart: got %h", g); end
            if (k == 4 && g !== {2'b10, 7'h3F, 1'b0}) begin errors++; $display("FAIL midrst_cleared: got %h", g); end
        end
        checks += 2;
    endtask

    task automatic test_active_low();
        exp_t e; logic [9:0] g, ga;
        do_reset();
        wr_en = 1'b1; wr_data = 8'h01; wr_dp = 2'b00;
        for (int k = 0; k < 8; k++) begin
            step(e, g, ga);
            wr_en = 1'b0;
            checks++;
            if (ga !== ~e) begin errors++; $display("FAIL al_model edge %0d: got %h expected %h", k, ga, ~e); end
            if (k == 1 || k == 2) begin
                checks++;
                if (ga !== {2'b10, 7'h79, 1'b1}) begin errors++; $display("FAIL al_lit edge %0d: got %h expected %h", k, ga, {2'b10, 7'h79, 1'b1}); end
            end
            if (k == 3) begin
                checks++;
                if (ga !== {2'b11, 7'h7F, 1'b1}) begin errors++; $display("FAIL al_blank edge 3: got %h expected %h", ga, {2'b11, 7'h7F, 1'b1}); end
            end
        end
    endtask

    task automatic test_leading_zero();
        exp_t e; logic [9:0] g, ga;
        logic [6:0] want_hi;
`ifdef LEADING_ZERO_BLANK_EN
        want_hi = 7'h00;
`else
        want_hi = 7'h3F;
`endif
        do_reset();
        wr_en = 1'b1; wr_data = 8'h05; wr_dp = 2'b10;
        for (int k = 0; k < 8; k++) begin
            step(e, g, ga);
            wr_en = 1'b0;
            checks++;
            if (g !== e) begin errors++; $display("FAIL lz_model edge %0d: got %h expected %h", k, g, e); end
            if (k == 1) begin
                checks++;
                if (g !== {2'b01, 7'h6D, 1'b0}) begin errors++; $display("FAIL lz_dig0 edge 1: got %h", g); end
            end
            if (k == 5) begin
                checks++;
                if (g !== {2'b10, want_hi, 1'b1}) begin errors++; $display("FAIL lz_dig1 edge 5: got %h expected %h", g, {2'b10, want_hi, 1'b1}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [9:0] g, ga;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            wr_en   = (k < 14);
            wr_data = 8'($urandom);
            wr_dp   = 2'($urandom);
            step(e, g, ga);
            checks++;
            if (g !== e) begin errors++; $display("FAIL b2b edge %0d: got %h expected %h", k, g, e); end
            checks++;
            if (ga !== ~e) begin errors++; $display("FAIL b2b_al edge %0d: got %h expected %h", k, ga, ~e); end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        test_reset();
        test_scan();
        test_write_on_tick();
        test_mid_reset();
        test_active_low();
        test_leading_zero();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
